// File: rtl/pitch_freq_module.sv
// pitch_freq_module
//   Converts a pitch lag (in samples) into a smoothed frequency in Hz.
//   A restoring shift-subtract divider computes floor(SAMPLE_RATE / tau),
//   one quotient bit per clock (MSB first). A 3-point median filter over the
//   recent voiced quotients then suppresses single-frame octave errors.
//   Lags below MIN_TAU are treated as unvoiced. They bypass the divider,
//   report freq=0 and clear the filter history.
//
// Ports
//   clk      in   single clock, all state updates on posedge
//   reset    in   synchronous, active-high reset
//   start    in   request strobe, accepted only while ready=1
//   min_tau  in   [TAU_WIDTH-1:0] lag from the threshold search, 0 = no pitch
//   ready    out  idle and able to accept start
//   freq     out  [FREQ_WIDTH-1:0] smoothed frequency in Hz, held between results
//   voiced   out  last result came from a voiced lag, held between results
//   valid    out  one-cycle pulse marking a new freq/voiced result
module pitch_freq_module #(
    parameter int unsigned TAU_WIDTH   = 8,
    parameter int unsigned FREQ_WIDTH  = 16,
    parameter int unsigned SAMPLE_RATE = 8000,
    parameter int unsigned MIN_TAU     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TAU_WIDTH-1:0]  min_tau,
    output logic                  ready,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic                  voiced,
    output logic                  valid
);

    localparam int unsigned CNT_W = $clog2(FREQ_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        MEDIAN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [TAU_WIDTH-1:0]  tau_q;
    logic                  unvoiced_q;
    logic [TAU_WIDTH:0]    rem_q;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom. After FREQ_WIDTH iterations the register holds the quotient.
    logic [FREQ_WIDTH-1:0] dq_q;
    logic [CNT_W-1:0]      iter_q;

    // The filter window is the current quotient plus the two previous voiced
    // quotients. hist_cnt_q saturates at 3 and counts results held since the
    // last clear.
    logic [FREQ_WIDTH-1:0] hist0_q, hist1_q;
    logic [1:0]            hist_cnt_q;

    logic                  tau_unvoiced;
    logic [TAU_WIDTH:0]    tau_ext;
    logic [TAU_WIDTH:0]    trial;
    logic                  qbit;
    logic [TAU_WIDTH:0]    rem_next;
    logic                  last_iter;
    logic [FREQ_WIDTH-1:0] med;
    logic [1:0]            hist_cnt_next;

    function automatic logic [FREQ_WIDTH-1:0] median3(
        input logic [FREQ_WIDTH-1:0] a,
        input logic [FREQ_WIDTH-1:0] b,
        input logic [FREQ_WIDTH-1:0] c
    );
        logic [FREQ_WIDTH-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      median3 = lo;
        else if (c > hi) median3 = hi;
        else             median3 = c;
    endfunction

    // Divider datapath and filter helpers
    always_comb begin
        tau_unvoiced = (min_tau < TAU_WIDTH'(MIN_TAU));
        tau_ext      = {1'b0, tau_q};
        trial        = {rem_q[TAU_WIDTH-1:0], dq_q[FREQ_WIDTH-1]};
        // rem_q stays below tau, so its top bit is always 0. It is still
        // included so that an over-range remainder would force a subtract.
        qbit         = rem_q[TAU_WIDTH] || (trial >= tau_ext);
        rem_next     = qbit ? (trial - tau_ext) : trial;
        last_iter    = (iter_q == CNT_W'(FREQ_WIDTH - 1));
        med          = median3(dq_q, hist0_q, hist1_q);
        hist_cnt_next = (hist_cnt_q == 2'd3) ? 2'd3 : hist_cnt_q + 2'd1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and ready
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = tau_unvoiced ? MEDIAN : DIVIDE;
            end
            DIVIDE: begin
                if (last_iter) state_next = MEDIAN;
            end
            MEDIAN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tau_q      <= '0;
            unvoiced_q <= 1'b0;
            rem_q      <= '0;
            dq_q       <= '0;
            iter_q     <= '0;
            hist0_q    <= '0;
            hist1_q    <= '0;
            hist_cnt_q <= '0;
            freq       <= '0;
            voiced     <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tau_q      <= min_tau;
                        unvoiced_q <= tau_unvoiced;
                        rem_q      <= '0;
                        dq_q       <= FREQ_WIDTH'(SAMPLE_RATE);
                        iter_q     <= '0;
                    end
                end
                DIVIDE: begin
                    rem_q  <= rem_next;
                    dq_q   <= {dq_q[FREQ_WIDTH-2:0], qbit};
                    iter_q <= iter_q + CNT_W'(1);
                end
                MEDIAN: begin
                    valid <= 1'b1;
                    if (unvoiced_q) begin
                        freq       <= '0;
                        voiced     <= 1'b0;
                        hist_cnt_q <= '0;
                    end else begin
                        hist1_q    <= hist0_q;
                        hist0_q    <= dq_q;
                        hist_cnt_q <= hist_cnt_next;
                        voiced     <= 1'b1;
                        // Filter only once three results precede this one.
                        freq       <= (hist_cnt_q == 2'd3) ? med : dq_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_freq_module.sv
// tb_pitch_freq_module
//   Directed-vector bench for pitch_freq_module with default parameters.
//   Expected values are hand-computed floor(8000 / tau) results and latencies.
module tb_pitch_freq_module;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  min_tau;
    logic        ready;
    logic [15:0] freq;
    logic        voiced;
    logic        valid;

    int vec_cnt = 0;
    int err_cnt = 0;

    pitch_freq_module #(
        .TAU_WIDTH  (8),
        .FREQ_WIDTH (16),
        .SAMPLE_RATE(8000),
        .MIN_TAU    (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .min_tau(min_tau),
        .ready  (ready),
        .freq   (freq),
        .voiced (voiced),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Steps edges until valid is seen (sampled #1 after each edge), bounded.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!valid && n < 40);
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_freq", freq, 0);
        check("rst_voiced", voiced, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] tau, input int exp_lat,
                       input logic [15:0] exp_freq, input logic exp_voiced);
        int n;
        @(negedge clk);
        start   = 1'b1;
        min_tau = tau;
        @(posedge clk); #1;
        start   = 1'b0;
        min_tau = ~tau;   // must not affect the accepted request
        check({tag, "_busy"}, ready, 0);
        wait_valid(n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_freq"}, freq, exp_freq);
        check({tag, "_voiced"}, voiced, exp_voiced);
        check({tag, "_ready"}, ready, 1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, valid, 0);
        check({tag, "_hold"}, freq, exp_freq);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        start   = 1'b0;
        min_tau = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_ready", ready, 1);
        check("init_valid", valid, 0);
        check("init_freq", freq, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic divides (history below 3 -> raw quotients)
        run("t100", 8'd100, 17, 16'd80, 1'b1);
        run("t255", 8'd255, 17, 16'd31, 1'b1);
        run("t3",   8'd3,   17, 16'd2666, 1'b1);

        // Unvoiced lags and the MIN_TAU boundary
        do_reset();
        run("t0", 8'd0, 1, 16'd0, 1'b0);
        run("t1", 8'd1, 1, 16'd0, 1'b0);
        run("t2", 8'd2, 17, 16'd4000, 1'b1);

        // Median sequence, then unvoiced clear
        do_reset();
        run("m1", 8'd100, 17, 16'd80, 1'b1);
        run("m2", 8'd50,  17, 16'd160, 1'b1);
        run("m3", 8'd100, 17, 16'd80, 1'b1);
        run("m4", 8'd100, 17, 16'd80, 1'b1);
        run("m5", 8'd0,   1,  16'd0, 1'b0);
        run("m6", 8'd50,  17, 16'd160, 1'b1);

        // Median rejecting an outlier: window {160,80,80} -> 80, {200,160,80} -> 160
        do_reset();
        run("o1", 8'd100, 17, 16'd80, 1'b1);
        run("o2", 8'd100, 17, 16'd80, 1'b1);
        run("o3", 8'd100, 17, 16'd80, 1'b1);
        run("o4", 8'd50,  17, 16'd80, 1'b1);
        run("o5", 8'd40,  17, 16'd160, 1'b1);

        // Start while busy is ignored
        do_reset();
        @(negedge clk);
        start = 1'b1; min_tau = 8'd40;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        start = 1'b1; min_tau = 8'd20;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(n);
        check("busy_lat", n + 5, 17);
        check("busy_freq", freq, 200);
        no_valid("busy_single", 30);

        // Reset mid-divide aborts
        do_reset();
        run("pre", 8'd100, 17, 16'd80, 1'b1);
        @(negedge clk);
        start = 1'b1; min_tau = 8'd80;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", valid, 0);
        check("abort_freq", freq, 0);
        check("abort_voiced", voiced, 0);
        check("abort_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0;
        no_valid("abort_quiet", 30);
        run("t80", 8'd80, 17, 16'd100, 1'b1);

        // Reset wins over start in the same cycle
        @(negedge clk);
        reset = 1'b1; start = 1'b1; min_tau = 8'd100;
        @(posedge clk); #1;
        check("rst_start_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        no_valid("rst_start_quiet", 25);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; min_tau = 8'd160;
        @(posedge clk); #1;
        wait_valid(n);
        check("b2b_lat0", n, 17);
        check("b2b_freq0", freq, 50);
        wait_valid(n);
        check("b2b_per1", n, 18);
        check("b2b_freq1", freq, 50);
        wait_valid(n);
        check("b2b_per2", n, 18);
        check("b2b_freq2", freq, 50);
        @(negedge clk);
        start = 1'b0;
        no_valid("b2b_drain", 25);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pitch_freq_module.md
PITCH_FREQ_MODULE -- requirements
Module: pitch_freq_module

Interface
REQ-001 Parameter TAU_WIDTH, default 8, width of the input lag.
REQ-002 Parameter FREQ_WIDTH, default 16, width of the frequency result and the number of divider iterations.
REQ-003 Parameter SAMPLE_RATE, default 8000, sample rate in Hz; SHALL be < 2**FREQ_WIDTH.
REQ-004 Parameter MIN_TAU, default 2, smallest lag treated as voiced.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request strobe; accepted only when ready=1.
REQ-008 min_tau  input  TAU_WIDTH  lag in samples from the threshold-search stage; 0 means no pitch found.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 freq  output  FREQ_WIDTH  smoothed frequency in Hz; held between results.
REQ-011 voiced  output  1  high when the last result came from a voiced lag; held between results.
REQ-012 valid  output  1  one-cycle pulse marking a new freq/voiced result.

Function
REQ-013 States SHALL be IDLE, DIVIDE, MEDIAN.
REQ-014 IDLE: ready=1; on a start edge, latch min_tau and drive ready=0 from the next cycle.
REQ-015 If the latched tau < MIN_TAU, the block SHALL go to MEDIAN with an unvoiced flag and skip DIVIDE.
REQ-016 Otherwise the block SHALL go to DIVIDE.
REQ-017 DIVIDE: restoring shift-subtract of SAMPLE_RATE by tau; one quotient bit per clock, MSB first.
REQ-018 DIVIDE SHALL use exactly FREQ_WIDTH iterations and a TAU_WIDTH+1-bit partial remainder.
REQ-019 The quotient SHALL be truncated (floor) and SHALL never overflow, given REQ-003.
REQ-020 MEDIAN, voiced case: push the quotient into a 3-entry history (oldest dropped).
REQ-021 If fewer than 3 voiced results have been held since the last clear, output the new quotient unchanged.
REQ-022 Otherwise output the median of the 3 entries; ties resolve to the repeated value.
REQ-023 MEDIAN, unvoiced case: clear history count to 0; freq=0, voiced=0.
REQ-024 MEDIAN lasts one cycle: register freq, voiced, valid=1, return to IDLE, and assert ready with valid.
REQ-025 Voiced latency: valid high in the cycle after the (FREQ_WIDTH+1)th edge following the start-accepting edge (17 for default).
REQ-026 Unvoiced latency: valid high in the cycle after the 1st edge following the start-accepting edge.
REQ-027 start while ready=0 SHALL be ignored with no effect.
REQ-028 min_tau changes after acceptance SHALL have no effect.
REQ-029 start asserted in the same cycle as valid (ready=1) SHALL be accepted normally.
REQ-030 valid SHALL be 0 in every cycle not covered by REQ-025/REQ-026.

Reset
REQ-031 While reset=1 at a clock edge: state=IDLE, ready=1, valid=0, freq=0, voiced=0, history count=0, divider registers=0.
REQ-032 Reset asserted mid-DIVIDE or mid-MEDIAN SHALL abort the operation with no valid pulse.
REQ-033 Reset SHALL take priority over start in the same cycle.

Verification
REQ-034 Defaults, after reset: start with tau=100 -> valid at 17 cycles, freq=80, voiced=1; then tau=255 -> freq=31; then tau=3 -> freq=2666.
REQ-035 tau=0, then separately tau=1 -> valid after 1 cycle, freq=0, voiced=0; ready returns high with valid.
REQ-036 Median: taus 100, 50, 100, 100 -> freq 80, 160, 80, 80; then tau=0 -> freq 0; then tau=50 -> 160 raw (history cleared).
REQ-037 Busy: start with tau=40 is accepted; start with tau=20 pulsed 5 cycles later is ignored -> single valid, freq=200.
REQ-038 Reset 8 cycles into DIVIDE -> no valid, outputs zero, ready=1 next cycle; new start with tau=80 -> freq=100.
REQ-039 Back-to-back: start held high continuously with tau=160 -> valid every 18 cycles, freq=50.
